uart_tx_arbiter: RTL

Shares the single UART transmitter between two requesters: port 0 for CPU MMIO writes and port 1 for the result-dump engine. Each request carries a 16-bit word that is sent as one or two bytes.
The block sequences the transmitter's TX_EN/TX_STATUS handshake byte by byte and grants the requesters round-robin.
It sits between the peripheral bus controller and the UART transmitter, replacing direct TX_EN drive from the bus controller.

---
 rtl/uart_tx_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between requester 0 (CPU MMIO) and
// requester 1 (result-dump engine). Each accepted 16-bit word is sent as
// one or two bytes through the TX_EN / TX_STATUS handshake, and the two
// requesters are granted round-robin.
//
// Build option: define UART_TX_TIMEOUT_EN to bound the wait for TX_STATUS
// to fall after a start pulse and to enable the sticky err_timeout flag.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | no transfer; ready offered to the selected requester
// ST_SEND      | byte pending; pulse TX_EN once the transmitter is idle
// ST_WAIT_LOW  | pulse issued; waiting for the transmitter to go busy
// ST_WAIT_HIGH | transmitter busy; waiting for it to return to idle
module uart_tx_arbiter #(
    parameter int TIMEOUT   = 16,
    parameter int LSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    input  logic        req0_two,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    input  logic        req1_two,
    output logic        req1_ready,
    input  logic        TX_STATUS,
    output logic        TX_EN,
    output logic [7:0]  UART_TXD,
    output logic        busy,
    output logic        grant,
    input  logic        err_clr,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_LOW,
        ST_WAIT_HIGH
    } state_t;

    state_t      state_q;
    logic [15:0] hold_q;
    logic [1:0]  cnt_q;
    logic        tx_en_q;
    logic [7:0]  txd_q;
    logic        busy_q;
    logic        grant_q;
    logic        last_q;

    logic        sel;
    logic        accept;
    logic [7:0]  cur_byte;
    logic [15:0] hold_shift_d;

    // Pick the requester to offer ready to; on a tie the one not served last wins.
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
            sel = ~last_q;
        end else if (req1_valid) begin
            sel = 1'b1;
        end
    end

    assign req0_ready = (state_q == ST_IDLE) && req0_valid && !sel;
    assign req1_ready = (state_q == ST_IDLE) && req1_valid && sel;
    assign accept     = req0_ready || req1_ready;

    // The byte to send is always taken from the same end of the hold register;
    // after the first byte the register shifts the second byte into that slot.
    always_comb begin
        if (LSB_FIRST != 0) begin
            cur_byte     = hold_q[7:0];
            hold_shift_d = {8'h00, hold_q[15:8]};
        end else begin
            cur_byte     = hold_q[15:8];
            hold_shift_d = {hold_q[7:0], 8'h00};
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

    logic [7:0] tmo_q;
    logic       err_q;
    logic       tmo_fire;

    // Down-counter reaches zero after TIMEOUT cycles in WAIT_LOW without TX_STATUS falling.
    assign tmo_fire = (state_q == ST_WAIT_LOW) && TX_STATUS && (tmo_q == 8'd0);

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (tmo_fire) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign err_timeout = err_q;
`else
    logic unused_tmo;
    assign unused_tmo  = ^{err_clr, (TIMEOUT != 0)};
    assign err_timeout = 1'b0;
`endif

    // Arbitration and byte sequencing FSM with registered transmitter outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= 16'h0000;
            cnt_q   <= 2'd0;
            tx_en_q <= 1'b0;
            txd_q   <= 8'h00;
            busy_q  <= 1'b0;
            grant_q <= 1'b1;
            last_q  <= 1'b1;
`ifdef UART_TX_TIMEOUT_EN
            tmo_q   <= 8'd0;
`endif
        end else begin
            tx_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        hold_q  <= sel ? req1_data : req0_data;
                        cnt_q   <= (sel ? req1_two : req0_two) ? 2'd2 : 2'd1;
                        grant_q <= sel;
                        busy_q  <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (TX_STATUS) begin
                        txd_q   <= cur_byte;
                        tx_en_q <= 1'b1;
                        cnt_q   <= cnt_q - 2'd1;
`ifdef UART_TX_TIMEOUT_EN
                        tmo_q   <= TMO_LOAD;
`endif
                        state_q <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!TX_STATUS) begin
                        state_q <= ST_WAIT_HIGH;
                    end
`ifdef UART_TX_TIMEOUT_EN
                    else if (tmo_fire) begin
                        state_q <= ST_WAIT_HIGH;
                    end else begin
                        tmo_q <= tmo_q - 8'd1;
                    end
`endif
                end
                ST_WAIT_HIGH: begin
                    if (TX_STATUS) begin
                        if (cnt_q != 2'd0) begin
                            hold_q  <= hold_shift_d;
                            state_q <= ST_SEND;
                        end else begin
                            last_q  <= grant_q;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign TX_EN    = tx_en_q;
    assign UART_TXD = txd_q;
    assign busy     = busy_q;
    assign grant    = grant_q;

endmodule
